// File: rtl/ps2_pkg.sv
// Shared constants and helpers for the PS/2 keyboard receiver and decoder.
package ps2_pkg;

   localparam logic [7:0] PS2_BREAK  = 8'hF0;
   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam int         FRAME_BITS = 11;

   // Lowercase ASCII for scan-code set 2; anything not listed maps to 0x00.
   function automatic logic [7:0] scan_to_ascii(input logic [7:0] code);
      logic [7:0] ascii;
      case (code)
         8'h1C: ascii = 8'h61;  8'h32: ascii = 8'h62;  8'h21: ascii = 8'h63;
         8'h23: ascii = 8'h64;  8'h24: ascii = 8'h65;  8'h2B: ascii = 8'h66;
         8'h34: ascii = 8'h67;  8'h33: ascii = 8'h68;  8'h43: ascii = 8'h69;
         8'h3B: ascii = 8'h6A;  8'h42: ascii = 8'h6B;  8'h4B: ascii = 8'h6C;
         8'h3A: ascii = 8'h6D;  8'h31: ascii = 8'h6E;  8'h44: ascii = 8'h6F;
         8'h4D: ascii = 8'h70;  8'h15: ascii = 8'h71;  8'h2D: ascii = 8'h72;
         8'h1B: ascii = 8'h73;  8'h2C: ascii = 8'h74;  8'h3C: ascii = 8'h75;
         8'h2A: ascii = 8'h76;  8'h1D: ascii = 8'h77;  8'h22: ascii = 8'h78;
         8'h35: ascii = 8'h79;  8'h1A: ascii = 8'h7A;
         8'h45: ascii = 8'h30;  8'h16: ascii = 8'h31;  8'h1E: ascii = 8'h32;
         8'h26: ascii = 8'h33;  8'h25: ascii = 8'h34;  8'h2E: ascii = 8'h35;
         8'h36: ascii = 8'h36;  8'h3D: ascii = 8'h37;  8'h3E: ascii = 8'h38;
         8'h46: ascii = 8'h39;
         8'h29: ascii = 8'h20;  8'h5A: ascii = 8'h0D;
         default: ascii = 8'h00;
      endcase
      return ascii;
   endfunction

   // Odd parity: data bits plus parity bit must contain an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: line synchronisers, falling-edge detect, shift register, timeout.
// Parity enforcement is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       rx_valid
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef PS2_PARITY_CHECK_EN
   localparam logic CHECK_PARITY = 1'b1;
`else
   localparam logic CHECK_PARITY = 1'b0;
`endif

   logic [2:0]            clk_sync_r;
   logic [1:0]            data_sync_r;
   logic [3:0]            bit_cnt_r;
   logic [FRAME_BITS-2:0] shift_r;
   logic [TW-1:0]         idle_cnt_r;
   logic [7:0]            rx_byte_r;
   logic                  rx_valid_r;
   logic                  fall_s;
   logic                  last_bit_s;
   logic                  timeout_s;
   logic                  frame_ok_s;
   logic [FRAME_BITS-1:0] frame_s;

   // Bit 0 of the frame ends up at frame_s[0] once all eleven bits are in.
   assign fall_s     = clk_sync_r[2] & ~clk_sync_r[1];
   assign frame_s    = {data_sync_r[1], shift_r};
   assign last_bit_s = (bit_cnt_r == 4'(FRAME_BITS - 1));
   assign timeout_s  = (idle_cnt_r == TW'(TIMEOUT_CYCLES - 1));

   // Frame acceptance: start low, stop high, and optionally odd parity.
   always_comb begin
      frame_ok_s = ~frame_s[0] & frame_s[10] &
                   (odd_parity_ok(frame_s[8:1], frame_s[9]) | ~CHECK_PARITY);
   end

   // Synchronisers, frame shifting and stall timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync_r  <= 3'b111;
         data_sync_r <= 2'b11;
         bit_cnt_r   <= 4'd0;
         shift_r     <= '0;
         idle_cnt_r  <= '0;
         rx_byte_r   <= 8'h00;
         rx_valid_r  <= 1'b0;
      end else begin
         clk_sync_r  <= {clk_sync_r[1:0], ps2_clk};
         data_sync_r <= {data_sync_r[0], ps2_data};
         rx_valid_r  <= 1'b0;
         if (fall_s) begin
            shift_r    <= frame_s[FRAME_BITS-1:1];
            idle_cnt_r <= '0;
            if (last_bit_s) begin
               bit_cnt_r  <= 4'd0;
               rx_valid_r <= frame_ok_s;
               rx_byte_r  <= frame_s[8:1];
            end else begin
               bit_cnt_r <= bit_cnt_r + 4'd1;
            end
         end else if (bit_cnt_r != 4'd0) begin
            if (timeout_s) begin
               bit_cnt_r  <= 4'd0;
               idle_cnt_r <= '0;
            end else begin
               idle_cnt_r <= idle_cnt_r + TW'(1);
            end
         end else begin
            idle_cnt_r <= '0;
         end
      end
   end

   assign rx_byte  = rx_byte_r;
   assign rx_valid = rx_valid_r;

endmodule

// File: rtl/ps2_kbd_decoder.sv
// PS/2 keyboard decoder: tracks E0/F0 prefixes and presents last make code, ASCII, key-held.
// Optional parity enforcement in the receiver via PS2_PARITY_CHECK_EN.
module ps2_kbd_decoder
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] ps2_scanout,
   output logic [7:0] ps2_out,
   output logic       putdown
);

   logic [7:0] rx_byte_s;
   logic       rx_valid_s;

   logic [7:0] scan_r,  scan_s;
   logic [7:0] ascii_r, ascii_s;
   logic       held_r,  held_s;
   logic       brk_r,   brk_s;
   logic       ext_r,   ext_s;

   ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
      .clk      (clk),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .rx_byte  (rx_byte_s),
      .rx_valid (rx_valid_s)
   );

   // Decoder state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_r  <= 8'h00;
         ascii_r <= 8'h00;
         held_r  <= 1'b0;
         brk_r   <= 1'b0;
         ext_r   <= 1'b0;
      end else begin
         scan_r  <= scan_s;
         ascii_r <= ascii_s;
         held_r  <= held_s;
         brk_r   <= brk_s;
         ext_r   <= ext_s;
      end
   end

   // Next-state: prefixes arm flags, a release only drops the key currently shown.
   always_comb begin
      scan_s  = scan_r;
      ascii_s = ascii_r;
      held_s  = held_r;
      brk_s   = brk_r;
      ext_s   = ext_r;
      if (rx_valid_s) begin
         case (rx_byte_s)
            PS2_EXT:   ext_s = 1'b1;
            PS2_BREAK: brk_s = 1'b1;
            default: begin
               if (brk_r) begin
                  if (rx_byte_s == scan_r) begin
                     held_s = 1'b0;
                  end else begin
                     held_s = held_r;
                  end
                  brk_s = 1'b0;
                  ext_s = 1'b0;
               end else begin
                  scan_s  = rx_byte_s;
                  held_s  = 1'b1;
                  ascii_s = ext_r ? 8'h00 : scan_to_ascii(rx_byte_s);
                  ext_s   = 1'b0;
               end
            end
         endcase
      end else begin
         scan_s = scan_r;
      end
   end

   // Outputs come straight from the state registers.
   always_comb begin
      ps2_scanout = scan_r;
      ps2_out     = ascii_r;
      putdown     = held_r;
   end

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Self-checking bench for ps2_kbd_decoder: directed test plan plus randomized key traffic.
module tb_ps2_kbd_decoder;

   localparam int TO = 200;
`ifdef PS2_PARITY_CHECK_EN
   localparam bit PARITY_EN = 1'b1;
`else
   localparam bit PARITY_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] ps2_scanout;
   logic [7:0] ps2_out;
   logic       putdown;

   int checks = 0;
   int errors = 0;

   logic [7:0] amap [256];
   logic [7:0] m_scan, m_ascii;
   logic       m_held, m_brk, m_ext;

   always #5 clk = ~clk;

   ps2_kbd_decoder #(.TIMEOUT_CYCLES(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .ps2_scanout (ps2_scanout),
      .ps2_out     (ps2_out),
      .putdown     (putdown)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_scan"}, ps2_scanout, m_scan);
      chk({tag, "_ascii"}, ps2_out, m_ascii);
      chk({tag, "_held"}, {7'd0, putdown}, {7'd0, m_held});
   endtask

   task automatic model_reset();
      m_scan = 8'h00; m_ascii = 8'h00; m_held = 1'b0; m_brk = 1'b0; m_ext = 1'b0;
   endtask

   // Keyboard semantics as seen by the host, one received byte at a time.
   task automatic model_byte(input logic [7:0] b);
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else if (m_brk) begin
         if (b == m_scan) m_held = 1'b0;
         m_brk = 1'b0;
         m_ext = 1'b0;
      end else begin
         m_scan  = b;
         m_held  = 1'b1;
         m_ascii = m_ext ? 8'h00 : amap[b];
         m_ext   = 1'b0;
      end
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      repeat (5) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (10) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_stop, input bit bad_par,
                             input string tag);
      logic par;
      par = ~(^b) ^ bad_par;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(par);
      send_bit(~bad_stop);
      ps2_data = 1'b1;
      if (!bad_stop && (!bad_par || !PARITY_EN)) model_byte(b);
      repeat (2) @(negedge clk);
      check_all(tag);
   endtask

   task automatic send_partial(input int nbits);
      for (int i = 0; i < nbits; i++) send_bit(i == 0 ? 1'b0 : 1'($urandom_range(0, 1)));
      ps2_data = 1'b1;
      repeat (TO + 20) @(negedge clk);
   endtask

   initial begin
      logic [7:0] letters [26];
      logic [7:0] digits [10];
      logic [7:0] pool [16];
      logic [7:0] code;
      int r;
      letters = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
                  8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
                  8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
      digits  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
      pool    = '{8'h1C, 8'h32, 8'h1A, 8'h4D, 8'h45, 8'h16, 8'h46, 8'h29, 8'h5A, 8'h75,
                  8'h05, 8'h12, 8'h76, 8'h6B, 8'h2C, 8'h3E};
      for (int i = 0; i < 256; i++) amap[i] = 8'h00;
      for (int i = 0; i < 26; i++) amap[letters[i]] = 8'h61 + 8'(i);
      for (int i = 0; i < 10; i++) amap[digits[i]] = 8'h30 + 8'(i);
      amap[8'h29] = 8'h20;
      amap[8'h5A] = 8'h0D;

      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_all("reset");

      send_frame(8'h1C, 1'b0, 1'b0, "make_a");
      chk("make_a_lit", ps2_out, 8'h61);
      send_frame(8'hF0, 1'b0, 1'b0, "brk_pfx");
      send_frame(8'h1C, 1'b0, 1'b0, "brk_a");

      send_frame(8'hE0, 1'b0, 1'b0, "ext_pfx");
      send_frame(8'h75, 1'b0, 1'b0, "ext_make");
      send_frame(8'hE0, 1'b0, 1'b0, "ext_pfx2");
      send_frame(8'hF0, 1'b0, 1'b0, "ext_brk_pfx");
      send_frame(8'h75, 1'b0, 1'b0, "ext_brk");

      send_frame(8'h16, 1'b0, 1'b0, "roll_1");
      send_frame(8'h1E, 1'b0, 1'b0, "roll_2");
      send_frame(8'hF0, 1'b0, 1'b0, "roll_pfx");
      send_frame(8'h16, 1'b0, 1'b0, "roll_brk1");
      chk("roll_lit", ps2_out, 8'h32);

      send_frame(8'h1C, 1'b1, 1'b0, "bad_stop");
      send_partial(5);
      send_frame(8'h29, 1'b0, 1'b0, "after_to");
      chk("space_lit", ps2_out, 8'h20);
      send_frame(8'h1C, 1'b0, 1'b1, "bad_par");

      send_partial(0);
      for (int i = 0; i < 4; i++) send_bit(i == 0 ? 1'b0 : 1'b1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      model_reset();
      check_all("mid_rst");
      rst = 1'b0;
      repeat (3) @(negedge clk);
      send_frame(8'h5A, 1'b0, 1'b0, "post_rst");

      for (int n = 0; n < 30; n++) begin
         r = $urandom_range(0, 9);
         code = pool[$urandom_range(0, 15)];
         case (r)
            0, 1, 2, 3: send_frame(code, 1'b0, 1'b0, "rnd_make");
            4, 5: begin
               if ($urandom_range(0, 1) == 1) code = m_scan;
               send_frame(8'hF0, 1'b0, 1'b0, "rnd_bpfx");
               send_frame(code, 1'b0, 1'b0, "rnd_brk");
            end
            6: begin
               send_frame(8'hE0, 1'b0, 1'b0, "rnd_epfx");
               send_frame(code, 1'b0, 1'b0, "rnd_emake");
            end
            7: begin
               if ($urandom_range(0, 1) == 1) code = m_scan;
               send_frame(8'hE0, 1'b0, 1'b0, "rnd_epfx2");
               send_frame(8'hF0, 1'b0, 1'b0, "rnd_ebpfx");
               send_frame(code, 1'b0, 1'b0, "rnd_ebrk");
            end
            8: send_frame(code, 1'($urandom_range(0, 1)), 1'b1, "rnd_bad");
            default: begin
               send_partial($urandom_range(1, 10));
               send_frame(code, 1'b0, 1'b0, "rnd_to");
            end
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_kbd_decoder.md
Name: ps2_kbd_decoder

Overview:
- PS/2 keyboard receiver and decoder. It samples the raw ps2_clk/ps2_data lines in the system clock domain and deframes 11-bit device-to-host frames.
- It tracks make/break (F0) and extended (E0) prefixes and presents three results:
  - the last make scan code;
  - its lowercase ASCII translation;
  - a key-held flag.
- It feeds the seven-segment display block, with ASCII on the high byte and the scan code on the low byte.

Parameters:
- TIMEOUT_CYCLES, default 50000: number of system clocks with no ps2_clk falling edge after which a partial frame is abandoned.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous active-high reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- ps2_scanout  out  8  last accepted non-prefix make code.
- ps2_out  out  8  ASCII of ps2_scanout; 0x00 if unmapped or extended.
- putdown  out  1  1 while the key in ps2_scanout is held.

Behaviour:
- Reset: ps2_scanout=0x00, ps2_out=0x00, putdown=0; bit counter, shift register, break flag and extended flag all cleared.
- Input sync: ps2_clk and ps2_data each pass through a 2-FF synchroniser. A third ps2_clk flop feeds a falling-edge detector (previous=1, current=0).
- Frame capture:
  - On each falling edge, shift in synchronised ps2_data.
  - Bit order: start(0), D0..D7 LSB first, odd parity, stop(1).
  - On the 11th bit, the frame is complete and the counter returns to 0.
  - A frame is valid when start=0 and stop=1; parity is covered under Optional Feature.
  - Invalid frames are silently discarded.
- Timeout: if the bit counter is nonzero and TIMEOUT_CYCLES clocks pass without a falling edge, the counter returns to 0 and the partial frame is dropped.
- Byte processing happens in the clock after a valid frame completes. Outputs are registered, so latency is 1 clk after the stop-bit edge is detected.
  - Byte 0xE0: set the extended flag; outputs unchanged.
  - Byte 0xF0: set the break flag; outputs unchanged.
  - Other byte with the break flag set (release):
    - if byte == ps2_scanout, putdown <= 0;
    - clear the break and extended flags;
    - ps2_scanout and ps2_out hold their values.
  - Other byte with no break flag (make):
    - ps2_scanout <= byte, putdown <= 1;
    - ps2_out <= ASCII(byte), or 0x00 if the extended flag is set or the byte is unmapped;
    - clear the extended flag.
- Typematic repeat (the same make code while held) rewrites identical values; putdown stays 1.
- A new key made while another is held takes over the outputs. A later release of the old key does not clear putdown.
- Reset mid-frame aborts the frame; the next start bit begins a fresh frame.
- ASCII map (lowercase):
  - letters: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z;
  - digits: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9';
  - others: 29 space (0x20), 5A CR (0x0D).

Optional Feature:
- Macro PS2_PARITY_CHECK_EN.
- Defined: a frame also needs ^{D7..D0,parity}==1. Frames failing this are discarded with no state change, including prefix flags.
- Undefined: the parity bit is shifted in but ignored.

Decomposition:
- Package ps2_pkg holds:
  - constants PS2_BREAK=8'hF0, PS2_EXT=8'hE0, FRAME_BITS=11;
  - a function scan_to_ascii(input 8-bit) returning 8 bits, implemented as a case table.
- One natural sub-module, ps2_rx: synchroniser, edge detect, shift register and timeout. It emits an 8-bit byte with a 1-cycle valid strobe.
- The decoder FSM (flags plus output registers) stays in the top-level block.

Test Plan:
- Reset: hold rst for 2 clk -> ps2_scanout=0x00, ps2_out=0x00, putdown=0.
- Press 'a': send frame 0x1C (parity 0) -> within 2 clk of the stop edge, ps2_scanout=0x1C, ps2_out=0x61, putdown=1. Then send F0,1C -> putdown=0, ps2_scanout still 0x1C.
- Extended: send E0,75 -> ps2_scanout=0x75, ps2_out=0x00, putdown=1. Then send E0,F0,75 -> putdown=0.
- Rollover: make 0x16 ('1'), make 0x1E ('2'), break 0x16 -> ps2_scanout=0x1E, ps2_out=0x32, putdown=1.
- Bad frame: stop bit=0 carrying 0x1C -> no output change. Send 5 bits then idle > TIMEOUT_CYCLES, then a clean frame 0x29 -> ps2_out=0x20.
- With PS2_PARITY_CHECK_EN: 0x1C with wrong parity -> ignored. Without the macro, the same frame is accepted -> ps2_scanout=0x1C.
